knn_vote_controller: RTL
========================

# knn_vote_controller

Sequencer for the K=5 nearest-neighbour vote path. For each query it accepts a stream of training-sample distances, each tagged with a 1-bit group label, and keeps a sorted list of the 5 smallest. At end of stream it forms the 5-bit group-bit vector for the majority-vote decider and registers the classification result with a one-cycle valid pulse. It sits between the distance-computation pipeline and the result interface.

## Interface
- DIST_W, 16, distance width in bits (unsigned)
- CNT_W, 10, width of sample count

- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- i_start  input  1  start a query; sampled only in IDLE
- i_num_samples  input  CNT_W  number of distances in this query; captured on accepted i_start
- i_dist_valid  input  1  i_dist/i_dist_group valid
- i_dist  input  DIST_W  distance of current training sample
- i_dist_group  input  1  group label of current sample
- o_dist_ready  output  1  controller can accept a distance
- o_busy  output  1  query in progress (state != IDLE)
- o_valid  output  1  one-cycle result strobe
- o_group  output  1  majority group of the 5 nearest samples
- o_5_smallest_distances_group_bit  output  5  group bits of the 5 nearest samples, bit 0 = nearest

## Operation
- States: IDLE, COLLECT, DECIDE.
- IDLE: on i_start, capture i_num_samples into the remaining counter and init all 5 slots to distance all-ones and group 0. Next state is COLLECT, or DECIDE if count==0. i_start is ignored outside IDLE.
- COLLECT: o_dist_ready=1. A sample is accepted when i_dist_valid & o_dist_ready.
  - Each accepted sample is inserted into the sorted list (ascending distance) and the 5th entry drops out.
  - Ties: a new sample is placed after existing equal distances. A new distance equal to all-ones is never inserted.
  - The remaining count decrements on each accept. The accept that brings it to 0 moves the state to DECIDE.
- DECIDE: register the vector of slot group bits into o_5_smallest_distances_group_bit. Set o_group = 1 iff popcount ≥ 3. Assert o_valid. Return to IDLE.
- Fewer than 5 samples: unfilled slots contribute group bit 0.
- o_group and the vector hold their value until the next DECIDE.
- Distances are unsigned compares at full DIST_W width.

## Timing
- Reset: state IDLE; o_dist_ready=0, o_busy=0, o_valid=0, o_group=0, vector=5'b0; slots at all-ones/group 0.
- o_busy rises the cycle after the i_start edge.
- Throughput is one sample per cycle while in COLLECT.
- Latency: the last sample is accepted at edge t. o_valid is high from edge t+1 to edge t+2, and o_busy is low after t+1.
- A new i_start is accepted in the cycle o_valid is high, since the state is already IDLE at that point.
- Reset mid-query: immediate abort to the reset values; no o_valid.
- i_dist_valid while not ready: ignored; the sample is not consumed.

## Configuration
- KNN_VOTE_ABORT_EN defined:
  - Adds input port i_abort (1 bit).
  - i_abort high in COLLECT or DECIDE returns to IDLE at the next edge, with no o_valid and o_group/vector unchanged.
  - i_abort has priority over a simultaneous accept or DECIDE.
  - In IDLE it is ignored.
- Not defined: the port is absent, and a query always completes.

## Test plan
- Reset released, no stimulus -> all outputs 0, o_dist_ready 0, o_busy 0.
- Query of 8 samples, distances 80,70,60,50,40,30,20,10 with groups 0,0,0,1,1,1,1,0 -> nearest 10,20,30,40,50 -> vector 5'b11110, o_group=1. o_valid is exactly one cycle, 1 cycle after the 8th accept.
- Query of 3 samples all group 1 -> vector 5'b00111, o_group=1. Query of 2 samples all group 1 -> 5'b00011, o_group=0.
- Tie: distances 5,5,5,5,5,5 with groups 1,1,1,0,0,0 -> first five kept, vector 5'b00111, o_group=1. i_dist_valid toggled randomly throughout the query -> same result.
- i_num_samples=0 -> o_valid the cycle after DECIDE entry, o_group=0. i_start pulsed mid-COLLECT -> ignored, count unaffected.
- rst asserted after 3 of 10 samples -> no o_valid, outputs 0. With KNN_VOTE_ABORT_EN, i_abort after 3 samples -> IDLE, previous o_group retained, next query correct.

Source files
------------

// File: rtl/knn_vote_controller.sv
// ============================================================================
//  Module      : knn_vote_controller
//  Description : K=5 nearest-neighbour vote sequencer. Keeps a sorted list of
//                the five smallest tagged distances of a query and emits the
//                group-bit vector and majority result with a one-cycle strobe.
//                Optional macro KNN_VOTE_ABORT_EN adds an i_abort input.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module knn_vote_controller #(
   parameter int DIST_W = 16,
   parameter int CNT_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
`ifdef KNN_VOTE_ABORT_EN
   input  logic              i_abort,
`endif
   input  logic              i_start,
   input  logic [CNT_W-1:0]  i_num_samples,
   input  logic              i_dist_valid,
   input  logic [DIST_W-1:0] i_dist,
   input  logic              i_dist_group,
   output logic              o_dist_ready,
   output logic              o_busy,
   output logic              o_valid,
   output logic              o_group,
   output logic [4:0]        o_5_smallest_distances_group_bit
);

   localparam int                K        = 5;
   localparam logic [DIST_W-1:0] DIST_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DECIDE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic [DIST_W-1:0] dist_q [K];
   logic [DIST_W-1:0] dist_d [K];
   logic [K-1:0]      grp_q, grp_d;
   logic              valid_q, valid_d;
   logic              group_q, group_d;
   logic [K-1:0]      vec_q, vec_d;

   logic [K-1:0]      keep;
   logic [DIST_W-1:0] ins_dist [K];
   logic [K-1:0]      ins_grp;
   logic [2:0]        pop;
   logic              accept;
   logic              abort;

   assign accept = (state_q == COLLECT) && i_dist_valid;

`ifdef KNN_VOTE_ABORT_EN
   assign abort = i_abort && (state_q != IDLE);
`else
   assign abort = 1'b0;
`endif

   // Sorted insertion: slots whose distance is <= the new one stay put (ties
   // keep the older sample first), the new sample lands in the first slot
   // that is larger, and everything below shifts down one place.
   always_comb begin
      for (int i = 0; i < K; i++) begin
         keep[i] = (dist_q[i] <= i_dist);
      end
      ins_dist[0] = keep[0] ? dist_q[0] : i_dist;
      ins_grp[0]  = keep[0] ? grp_q[0]  : i_dist_group;
      for (int i = 1; i < K; i++) begin
         if (keep[i]) begin
            ins_dist[i] = dist_q[i];
            ins_grp[i]  = grp_q[i];
         end else if (keep[i-1]) begin
            ins_dist[i] = i_dist;
            ins_grp[i]  = i_dist_group;
         end else begin
            ins_dist[i] = dist_q[i-1];
            ins_grp[i]  = grp_q[i-1];
         end
      end
   end

   // Number of group-1 samples among the current five slots.
   always_comb begin
      pop = 3'd0;
      for (int i = 0; i < K; i++) begin
         pop = pop + 3'(grp_q[i]);
      end
   end

   // Next-state and datapath update; every target holds its value by default.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      dist_d      = dist_q;
      grp_d       = grp_q;
      valid_d     = 1'b0;
      group_d     = group_q;
      vec_d       = vec_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  remaining_d = i_num_samples;
                  for (int i = 0; i < K; i++) begin
                     dist_d[i] = DIST_MAX;
                  end
                  grp_d   = '0;
                  state_d = (i_num_samples == '0) ? DECIDE : COLLECT;
               end
            end
            COLLECT: begin
               if (accept) begin
                  // An all-ones distance can never beat an empty slot.
                  if (i_dist != DIST_MAX) begin
                     dist_d = ins_dist;
                     grp_d  = ins_grp;
                  end
                  remaining_d = remaining_q - CNT_ONE;
                  if (remaining_q == CNT_ONE) begin
                     state_d = DECIDE;
                  end
               end
            end
            DECIDE: begin
               vec_d   = grp_q;
               group_d = (pop >= 3'd3);
               valid_d = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, slot list and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         for (int i = 0; i < K; i++) begin
            dist_q[i] <= DIST_MAX;
         end
         grp_q       <= '0;
         valid_q     <= 1'b0;
         group_q     <= 1'b0;
         vec_q       <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         dist_q      <= dist_d;
         grp_q       <= grp_d;
         valid_q     <= valid_d;
         group_q     <= group_d;
         vec_q       <= vec_d;
      end
   end

   assign o_dist_ready                     = (state_q == COLLECT);
   assign o_busy                           = (state_q != IDLE);
   assign o_valid                          = valid_q;
   assign o_group                          = group_q;
   assign o_5_smallest_distances_group_bit = vec_q;

endmodule

`default_nettype wire
